// File: rtl/fir_mac_seq.sv
// Sequencer for a single-MAC FIR: writes each new sample into a circular delay line,
// then walks the N+1 tap address pairs and strobes the accumulator and output register.
module fir_mac_seq #(
    parameter int N  = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          x_valid,
    output logic          x_we,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] h_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          y_load,
    output logic          y_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam logic [AW-1:0] KMAX = AW'(N);
    localparam logic [AW:0]   NP1  = (AW+1)'(N + 1);

    state_t        state;
    logic [AW-1:0] k;
    logic [AW-1:0] head;
    logic [AW-1:0] x_hold;
    logic [AW-1:0] h_hold;
    logic [AW-1:0] x_tap;
    logic [AW:0]   x_wrap;

    // Circular index (head - k) mod (N+1); N+1 need not be a power of two,
    // so the wrap adds N+1 explicitly in a widened sum.
    always_comb begin
        x_wrap = {1'b0, head} + NP1 - {1'b0, k};
        if (k > head)
            x_tap = x_wrap[AW-1:0];
        else
            x_tap = head - k;
    end

    assign busy    = (state != IDLE);
    assign wr_ptr  = head;
    assign x_we    = (state == IDLE) & x_valid & clk_en;
    assign acc_en  = (state == MAC) & clk_en;
    assign acc_clr = acc_en & (k == '0);
    assign y_load  = (state == DONE) & clk_en;

    // Outside MAC the addresses replay the last tap used, so they never wander.
    assign h_addr  = (state == MAC) ? k     : h_hold;
    assign x_addr  = (state == MAC) ? x_tap : x_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            head    <= '0;
            x_hold  <= '0;
            h_hold  <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clk_en) begin
            y_valid <= (state == DONE);
            if (x_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        state <= MAC;
                        k     <= '0;
                    end
                end
                MAC: begin
                    h_hold <= k;
                    x_hold <= x_tap;
                    if (k == KMAX)
                        state <= DONE;
                    else
                        k <= k + 1'b1;
                end
                DONE: begin
                    head  <= (head == KMAX) ? '0 : head + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench: a tap-history FIR model predicts each y and its enabled-cycle due time;
// a separate monitor pops on every y_valid rising edge.
module tb_fir_mac_seq;
    localparam int N  = 10;
    localparam int AW = 4;
    localparam int NT = N + 1;

    logic          clk, rst, clk_en, x_valid;
    logic          x_we, acc_clr, acc_en, y_load, y_valid, busy, overrun;
    logic [AW-1:0] wr_ptr, x_addr, h_addr;
    logic [7:0]    x_data;

    fir_mac_seq #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .x_valid(x_valid),
        .x_we(x_we), .wr_ptr(wr_ptr), .x_addr(x_addr), .h_addr(h_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .y_load(y_load), .y_valid(y_valid),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath driven by the sequencer: delay-line RAM, coefficient ROM, MAC, y register.
    logic [7:0] ram [0:15];
    int         h_rom [0:15];
    int         acc, y_reg;

    initial for (int i = 0; i < 16; i++) h_rom[i] = i + 1;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'd0;
        end else begin
            if (x_we) ram[wr_ptr] <= x_data;
            if (acc_en)
                acc <= acc_clr ? h_rom[h_addr] * int'(ram[x_addr])
                               : acc + h_rom[h_addr] * int'(ram[x_addr]);
            if (y_load) y_reg <= acc;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {int y; int due;} exp_t;
    exp_t expq[$];
    int   xs[$];
    int   ecyc = 0;
    bit   has_job = 0;
    int   jc0 = 0, jhead = 0, mwr = 0;
    bit   movr = 0;

    task automatic model_reset();
        has_job = 0; movr = 0; mwr = 0;
        expq.delete();
        xs.delete();
        for (int i = 0; i < NT; i++) xs.push_back(0);
    endtask

    // One clock: drive at negedge, check combinational outputs against the model, step.
    task automatic cyc(input bit xv, input int xd, input bit ce);
        bit mbusy, in_mac, in_done, exp_we;
        int kk, y;
        exp_t e;
        @(negedge clk);
        x_valid = xv; x_data = 8'(xd); clk_en = ce;
        #1;
        mbusy   = has_job && ecyc > jc0 && ecyc <= jc0 + N + 2;
        in_mac  = has_job && ecyc >= jc0 + 1 && ecyc <= jc0 + N + 1;
        in_done = has_job && ecyc == jc0 + N + 2;
        kk      = ecyc - jc0 - 1;
        exp_we  = xv && ce && !mbusy;
        chk("busy", busy, mbusy);
        chk("overrun", overrun, movr);
        chk("x_we", x_we, exp_we);
        chk("acc_en", acc_en, in_mac && ce);
        chk("acc_clr", acc_clr, in_mac && ce && kk == 0);
        chk("y_load", y_load, in_done && ce);
        if (in_mac) begin
            chk("h_addr", h_addr, kk);
            chk("x_addr", x_addr, (jhead - kk + NT) % NT);
        end
        if (exp_we) begin
            chk("wr_ptr", wr_ptr, mwr);
            xs.push_front(xd);
            void'(xs.pop_back());
            y = 0;
            for (int j = 0; j < NT; j++) y += h_rom[j] * xs[j];
            e.y = y; e.due = ecyc + N + 3;
            expq.push_back(e);
            has_job = 1; jc0 = ecyc; jhead = mwr;
            mwr = (mwr + 1) % NT;
        end else if (xv && ce) begin
            movr = 1;
        end
        @(posedge clk);
        if (ce) ecyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1);
    endtask

    // Asynchronous reset landing mid-cycle.
    task automatic do_reset();
        @(negedge clk);
        x_valid = 0; clk_en = 1;
        #2 rst = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_h_addr", h_addr, 0);
        chk("rst_x_addr", x_addr, 0);
        chk("rst_y_load", y_load, 0);
        chk("rst_overrun", overrun, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // Monitor
    bit yv_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && y_valid && !yv_prev) begin
                if (expq.size() == 0) begin
                    chk("unexpected_y_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("y", y_reg, e.y);
                    chk("y_latency", ecyc, e.due);
                end
            end
            yv_prev = y_valid;
        end
    end

    initial begin
        int raw;
        rst = 1; clk_en = 0; x_valid = 0; x_data = 0;
        model_reset();
        #12;
        chk("init_busy", busy, 0);
        chk("init_x_we", x_we, 0);
        chk("init_y_valid", y_valid, 0);
        @(negedge clk);
        rst = 0;

        // Idle after reset: addresses and strobes stay zero.
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1);
            chk("idle_h_addr", h_addr, 0);
            chk("idle_x_addr", x_addr, 0);
            chk("idle_wr_ptr", wr_ptr, 0);
            chk("idle_y_valid", y_valid, 0);
        end

        // Unit impulse followed by 11 zeros: y = 1..11 then 0, head wraps 10 -> 0.
        cyc(1, 1, 1);
        idle(12);
        for (int i = 0; i < 11; i++) begin
            cyc(1, 0, 1);
            idle(12);
        end
        idle(2);

        // Sample arriving 5 cycles into MAC is dropped and sets sticky overrun.
        cyc(1, 5, 1);
        idle(5);
        cyc(1, 9, 1);
        idle(6);
        cyc(1, 7, 1);
        idle(14);
        chk("overrun_sticky", overrun, 1);

        // Reset at k=6 aborts the walk; then a fresh full walk.
        cyc(1, 3, 1);
        idle(6);
        do_reset();
        idle(15);
        cyc(1, 200, 1);
        idle(14);

        // x_valid during the DONE cycle is an overrun; the next cycle accepts.
        cyc(1, 4, 1);
        idle(11);
        cyc(1, 8, 1);
        cyc(1, 6, 1);
        idle(14);
        chk("done_overrun", overrun, 1);
        do_reset();
        idle(3);

        // clk_en low for 3 cycles at k=4: walk freezes, latency grows by 3.
        cyc(1, 2, 1);
        raw = 1;
        idle(4);
        raw += 4;
        cyc(0, 0, 0);
        cyc(1, 99, 0);
        cyc(0, 0, 0);
        raw += 3;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1);
            raw++;
            #1;
            if (y_valid) break;
        end
        chk("gap_latency", raw, N + 3 + 3);
        idle(3);
        chk("gap_no_overrun", overrun, 0);

        // Randomized strobes, data and clock-enable drops.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) == 0, int'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
        idle(30);
        chk("drain_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Sequencer for a time-multiplexed, single-MAC FIR datapath of order N, which replaces the fully parallel tap path.
- On each input-sample strobe it:
  - writes the sample into a circular delay-line RAM;
  - walks all N+1 coefficient/sample address pairs;
  - drives accumulator clear/enable;
  - pulses the output-register load once the sum is complete.
- Sits between the sample-rate strobe generator and the coefficient ROM, delay-line RAM and MAC unit.

Parameters:
- N, 10, filter order (N+1 taps, N ≥ 1).
- AW, 4, address width for the coefficient and delay-line memories; 2**AW ≥ N+1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous reset, active-high.
- clk_en, input, 1, global clock enable. When 0, all state holds and all strobes are 0.
- x_valid, input, 1, one-cycle new-sample strobe.
- x_we, output, 1, delay-line write enable for the new sample at address wr_ptr.
- wr_ptr, output, AW, delay-line write address (current head).
- x_addr, output, AW, delay-line read address for the current tap.
- h_addr, output, AW, coefficient ROM address for the current tap.
- acc_clr, output, 1, accumulator loads the product instead of accumulating (first tap).
- acc_en, output, 1, accumulator update enable.
- y_load, output, 1, output register captures the accumulator.
- y_valid, output, 1, one-cycle pulse: new y is available.
- busy, output, 1, the sequencer is not in IDLE.
- overrun, output, 1, sticky flag: a sample arrived while busy.

Behaviour:
- Registers: state ∈ {IDLE, MAC, DONE}, tap counter k (AW bits), head pointer (AW bits), y_valid flop, overrun flop.
- Reset (async): state=IDLE, k=0, head=0, y_valid=0, overrun=0.
  - All combinational strobes are therefore 0, and wr_ptr, x_addr, h_addr are 0.
  - Reset mid-operation aborts the walk; the partial sum is never loaded.
- All register updates are qualified by clk_en. All strobes (x_we, acc_clr, acc_en, y_load) are ANDed with clk_en.
- IDLE:
  - wr_ptr=head.
  - x_we = x_valid & clk_en.
  - When x_valid & clk_en: next state MAC, k <= 0.
  - head does not advance yet.
- MAC (exactly N+1 enabled cycles, k = 0..N):
  - h_addr = k.
  - x_addr = (head − k) mod (N+1), computed without relying on a power-of-two wrap. If k > head, x_addr = head + N + 1 − k.
  - acc_en = 1; acc_clr = 1 only when k = 0.
  - k increments each enabled cycle. At k = N, next state is DONE.
- DONE (one enabled cycle):
  - y_load = 1.
  - head <= (head = N) ? 0 : head + 1.
  - Next state IDLE.
- y_valid is registered from y_load: high on the enabled cycle after DONE. It is cleared on the next enabled edge.
- Timing:
  - Latency from the x_valid edge to y_valid is N+3 enabled cycles.
  - Minimum x_valid spacing is N+3 cycles (13 for N=10).
- busy = (state ≠ IDLE).
- overrun:
  - Set on x_valid & clk_en while state ≠ IDLE. That sample is dropped: no x_we and no restart.
  - Cleared only by rst.
- x_valid arriving in the same cycle as the DONE→IDLE transition counts as an overrun. It is accepted only when state is IDLE.
- When x_valid arrives with clk_en=0, it is ignored entirely. No overrun is set.
- h_addr and x_addr hold their last values in IDLE/DONE. They are don't-care for the datapath but must be stable and deterministic (bench checks they equal 0 after reset).

Test Plan:
- Reset, then 20 idle cycles → all outputs 0, busy=0, overrun=0.
- One x_valid (N=10), checked cycle by cycle:
  - x_we=1 at wr_ptr=0;
  - 11 MAC cycles with h_addr=0..10 and x_addr=0,10,9,…,1;
  - acc_clr only on the first of them;
  - y_load on cycle 12, y_valid on cycle 13.
- Integration, 12 strobes spaced 13 cycles with a unit impulse and h=1..11 loaded in a MAC model:
  - wr_ptr sequence 0,1,…,10,0;
  - y outputs 1,2,…,11 then 0;
  - head wraps 10→0.
- x_valid pulsed 5 cycles into MAC → overrun=1 and stays 1; no x_we; walk completes unchanged; next correctly spaced sample is processed normally.
- Toggle clk_en=0 for 3 cycles at k=4 → k, state and addresses frozen; acc_en=0 during the gap; total latency extends by exactly 3 cycles.
- rst asserted at k=6 → immediate IDLE, head=0, no y_load or y_valid; a fresh sample afterwards yields a correct full walk.
